// File: rtl/ddr3_app_arbiter_if.sv
// Requester and MIG app_* signal bundle for ddr3_app_arbiter.
// slave = arbiter side; master = requesters plus MIG core.
interface ddr3_app_arbiter_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32,
  parameter int CNT_W  = 7
);
  logic              init_calib_complete;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic [CNT_W-1:0]  rd_outstanding;
  logic              rd_underflow_err;

  modport slave (
    input  init_calib_complete, wr_req, wr_addr, wr_data, rd_req, rd_addr,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output wr_ack, rd_ack, rd_data, rd_valid, app_en, app_cmd, app_addr,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
           rd_outstanding, rd_underflow_err
  );

  modport master (
    output init_calib_complete, wr_req, wr_addr, wr_data, rd_req, rd_addr,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  wr_ack, rd_ack, rd_data, rd_valid, app_en, app_cmd, app_addr,
           app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
           rd_outstanding, rd_underflow_err
  );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Round-robin write/read arbiter onto the MIG 7-series app_* interface,
// with outstanding-read tracking and registered in-order read return.
module ddr3_app_arbiter #(
  parameter int ADDR_W          = 29,
  parameter int DATA_W          = 256,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_W           = 7
) (
  input logic              ui_clk,
  input logic              sys_rst,
  ddr3_app_arbiter_if.slave bus
);

  // IDLE: arbitrate | ISSUE_WR: hold write until accepted | ISSUE_RD: hold read until accepted
  typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD} state_e;

  localparam logic [2:0]       CMD_WR  = 3'd0;
  localparam logic [2:0]       CMD_RD  = 3'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic              last_grant_rd_q, last_grant_rd_d;
  logic              app_en_q, app_en_d;
  logic [2:0]        app_cmd_q, app_cmd_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [DATA_W-1:0] app_wdf_data_q, app_wdf_data_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_outstanding_q, rd_outstanding_d;
  logic              rd_underflow_err_q, rd_underflow_err_d;

  logic wr_pending, rd_pending, wdf_wren, rd_accept;

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q            <= IDLE;
      last_grant_rd_q    <= 1'b0;
      app_en_q           <= 1'b0;
      app_cmd_q          <= '0;
      app_addr_q         <= '0;
      app_wdf_data_q     <= '0;
      wr_ack_q           <= 1'b0;
      rd_ack_q           <= 1'b0;
      rd_data_q          <= '0;
      rd_valid_q         <= 1'b0;
      rd_outstanding_q   <= '0;
      rd_underflow_err_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      last_grant_rd_q    <= last_grant_rd_d;
      app_en_q           <= app_en_d;
      app_cmd_q          <= app_cmd_d;
      app_addr_q         <= app_addr_d;
      app_wdf_data_q     <= app_wdf_data_d;
      wr_ack_q           <= wr_ack_d;
      rd_ack_q           <= rd_ack_d;
      rd_data_q          <= rd_data_d;
      rd_valid_q         <= rd_valid_d;
      rd_outstanding_q   <= rd_outstanding_d;
      rd_underflow_err_q <= rd_underflow_err_d;
    end
  end

  always_comb begin
    wr_pending = bus.wr_req;
    rd_pending = bus.rd_req & (rd_outstanding_q < CNT_MAX);
    wdf_wren   = app_en_q & bus.app_rdy & bus.app_wdf_rdy & (app_cmd_q == CMD_WR);
    rd_accept  = (state_q == ISSUE_RD) & app_en_q & bus.app_rdy;

    state_d         = state_q;
    last_grant_rd_d = last_grant_rd_q;
    app_en_d        = app_en_q;
    app_cmd_d       = app_cmd_q;
    app_addr_d      = app_addr_q;
    app_wdf_data_d  = app_wdf_data_q;
    wr_ack_d        = 1'b0;
    rd_ack_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.init_calib_complete) begin
          // With both sides pending, the side not served last time wins.
          if (wr_pending && (!rd_pending || last_grant_rd_q)) begin
            state_d         = ISSUE_WR;
            last_grant_rd_d = 1'b0;
            app_en_d        = 1'b1;
            app_cmd_d       = CMD_WR;
            app_addr_d      = bus.wr_addr;
            app_wdf_data_d  = bus.wr_data;
            wr_ack_d        = 1'b1;
          end else if (rd_pending) begin
            state_d         = ISSUE_RD;
            last_grant_rd_d = 1'b1;
            app_en_d        = 1'b1;
            app_cmd_d       = CMD_RD;
            app_addr_d      = bus.rd_addr;
            rd_ack_d        = 1'b1;
          end
        end
      end
      ISSUE_WR: begin
        if (wdf_wren) begin
          app_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      ISSUE_RD: begin
        if (rd_accept) begin
          app_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        app_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    rd_data_d          = bus.app_rd_data;
    rd_valid_d         = bus.app_rd_data_valid;
    rd_outstanding_d   = rd_outstanding_q;
    rd_underflow_err_d = rd_underflow_err_q |
                         (bus.app_rd_data_valid & (rd_outstanding_q == '0));
    if (rd_accept && !bus.app_rd_data_valid) begin
      rd_outstanding_d = rd_outstanding_q + CNT_ONE;
    end else if (!rd_accept && bus.app_rd_data_valid && (rd_outstanding_q != '0)) begin
      rd_outstanding_d = rd_outstanding_q - CNT_ONE;
    end
  end

  assign bus.app_en           = app_en_q;
  assign bus.app_cmd          = app_cmd_q;
  assign bus.app_addr         = app_addr_q;
  assign bus.app_wdf_data     = app_wdf_data_q;
  assign bus.app_wdf_wren     = wdf_wren;
  assign bus.app_wdf_end      = wdf_wren;
  assign bus.app_wdf_mask     = '0;
  assign bus.wr_ack           = wr_ack_q;
  assign bus.rd_ack           = rd_ack_q;
  assign bus.rd_data          = rd_data_q;
  assign bus.rd_valid         = rd_valid_q;
  assign bus.rd_outstanding   = rd_outstanding_q;
  assign bus.rd_underflow_err = rd_underflow_err_q;

endmodule

// File: doc/ddr3_app_arbiter.md
Name: ddr3_app_arbiter

Overview:
Two-port arbiter that shares the MIG 7-series user (app_*) interface between a write requester (sample loader) and a read requester (playback prefetch).
- Sequences each command through the app_en/app_rdy/app_wdf_rdy handshake.
- Round-robins between the two requesters when both are pending.
- Tracks outstanding reads and returns read data, in order, to the read requester.
- Sits between the MIG core and the sound-generation datapath, in the ui_clk domain.

Parameters:
- ADDR_W, 29, app address width.
- DATA_W, 256, app data width.
- MASK_W, 32, write-mask width (DATA_W/8).
- MAX_OUTSTANDING, 16, maximum accepted reads still awaiting app_rd_data_valid; power of two, at most 64.
- CNT_W, 7, width of rd_outstanding; must hold MAX_OUTSTANDING.

Ports:
- ui_clk  in  1  MIG user clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- init_calib_complete  in  1  MIG calibration done; no grants while low.
- wr_req  in  1  write request; hold high, with wr_addr/wr_data stable, until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse: write request latched.
- rd_req  in  1  read request; hold high, with rd_addr stable, until rd_ack.
- rd_addr  in  ADDR_W  read address.
- rd_ack  out  1  one-cycle pulse: read request latched.
- rd_data  out  DATA_W  returned read data.
- rd_valid  out  1  rd_data valid.
- app_en  out  1  to MIG.
- app_cmd  out  3  3'd0 write, 3'd1 read.
- app_addr  out  ADDR_W  to MIG.
- app_wdf_data  out  DATA_W  to MIG.
- app_wdf_wren  out  1  to MIG.
- app_wdf_end  out  1  to MIG; equals app_wdf_wren.
- app_wdf_mask  out  MASK_W  constant 0.
- app_rdy  in  1  from MIG.
- app_wdf_rdy  in  1  from MIG.
- app_rd_data  in  DATA_W  from MIG.
- app_rd_data_valid  in  1  from MIG.
- rd_outstanding  out  CNT_W  reads accepted but not yet returned.
- rd_underflow_err  out  1  sticky: app_rd_data_valid seen with rd_outstanding==0.

Behaviour:
- Reset is asynchronous on sys_rst low. All outputs, registers and counters reset to 0; state = IDLE; last_grant = WRITE. A reset mid-command drops app_en immediately; no command is retried.
- States are IDLE, ISSUE_WR and ISSUE_RD.
- IDLE behaviour:
  - No grant while init_calib_complete=0.
  - wr_pending = wr_req.
  - rd_pending = rd_req & (rd_outstanding < MAX_OUTSTANDING).
  - If only one side is pending, grant it. If both are pending, grant the side opposite last_grant.
  - On a grant: latch addr (and data for a write) into app_addr/app_wdf_data, set app_cmd, set app_en<=1, pulse the matching ack<=1 for one cycle, update last_grant, and go to the ISSUE state.
- ISSUE_WR:
  - app_wdf_wren = app_en & app_rdy & app_wdf_rdy & (app_cmd==0).
  - Accept = app_wdf_wren. On accept: app_en<=0, go to IDLE. Otherwise hold every app output stable.
- ISSUE_RD:
  - Accept = app_en & app_rdy. On accept: app_en<=0, go to IDLE, rd_outstanding +1.
- Throughput and latency:
  - At most one command per 2 cycles: grant cycle, then an issue cycle of at least 1.
  - From req to app_en: 1 cycle.
- Ack timing:
  - The ack is high in the same cycle as the first app_en cycle.
  - The requester may change req/addr/data only after sampling its ack. The arbiter does not sample req outside IDLE.
- init_calib_complete falling while in an ISSUE state: the current command completes normally; no new grants follow.
- Read return:
  - rd_data<=app_rd_data and rd_valid<=app_rd_data_valid, 1-cycle registered latency, no reordering.
  - rd_outstanding −1 on each app_rd_data_valid.
  - Accept and valid in the same cycle leave the count unchanged.
  - app_rd_data_valid with count 0: count stays 0, rd_underflow_err<=1 (cleared only by reset), data is still forwarded.
- Saturation: at rd_outstanding==MAX_OUTSTANDING, reads are blocked and writes still proceed.
- app_cmd holds its last value while app_en=0.

Test Plan:
- Reset, then init_calib_complete=0 with wr_req=1 and rd_req=1 for 50 cycles -> no ack, app_en=0, all outputs 0. Raise calib -> rd_ack first (last_grant reset to WRITE), then wr_ack.
- Single write wr_addr=0x40, wr_data=0xA5, app_rdy=app_wdf_rdy=1 -> app_en high 1 cycle; app_wdf_wren/end high that cycle with app_cmd=0 and app_addr=0x40; wr_ack pulse coincides.
- Write with app_wdf_rdy held low 5 cycles -> app_en and app_addr/data stay stable, wdf_wren=0. Release -> wdf_wren=1 exactly one cycle, then IDLE.
- Both requesters continuously high for 20 grants -> strictly alternating R,W,R,W…; 10 reads and 10 writes.
- 16 reads issued with no data returned (MAX_OUTSTANDING=16) -> rd_outstanding=16, 17th read not granted while writes continue. One app_rd_data_valid -> count 15, read granted.
- Read accept coincident with app_rd_data_valid -> count unchanged. app_rd_data_valid at count 0 -> rd_underflow_err=1, rd_valid pulses one cycle later. Assert sys_rst mid-ISSUE_RD -> app_en=0 immediately and error cleared.
